// File: rtl/addr_seq_pkg.sv
// addr_seq_pkg: shared FSM state type, default sizing constants and clog2 helper for addr_seq_gen
package addr_seq_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int DEPTH_DEF  = 15;
  localparam int NUM_RD_DEF = 3;
  localparam int STRIDE_DEF = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/addr_mod_add.sv
// addr_mod_add: combinational y = (a + inc) mod DEPTH for a < DEPTH, inc <= DEPTH (ports a, inc in; y out)
module addr_mod_add #(
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic [AW-1:0] a,
  input  logic [AW:0]   inc,
  output logic [AW-1:0] y
);
  localparam logic [AW:0] DW = (AW+1)'(DEPTH);
  logic [AW:0] sum;
  always_comb begin
    sum = {1'b0, a} + inc;
    y   = (sum >= DW) ? AW'(sum - DW) : AW'(sum);
  end
endmodule

// File: rtl/addr_seq_gen.sv
// addr_seq_gen: write pointer + NUM_RD-port strided read window sequencer (in: clk rst start stop wr_en rd_en; out: wr_addr rd_addr rd_valid full busy wr_wrap, plus wr_onehot under ADDR_SEQ_ONEHOT_EN)
module addr_seq_gen import addr_seq_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int STRIDE = STRIDE_DEF,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [AW-1:0]        wr_addr,
  output logic [NUM_RD*AW-1:0] rd_addr,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 busy,
  output logic                 wr_wrap
`ifdef ADDR_SEQ_ONEHOT_EN
  ,
  output logic [DEPTH-1:0]     wr_onehot
`endif
);
  localparam int OW  = clog2(DEPTH + 1);
  localparam int WIN = (NUM_RD > STRIDE) ? NUM_RD : STRIDE;
  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_base_q, rd_base_d, wr_nxt, rd_nxt;
  logic [OW-1:0] occ_q, occ_d;
  logic          wr_wrap_q, wr_wrap_d, run, wr_acc, rd_acc;
`ifdef ADDR_SEQ_ONEHOT_EN
  logic [DEPTH-1:0] onehot_q, onehot_d;
`endif
  addr_mod_add #(.DEPTH(DEPTH), .AW(AW)) u_wr_add (
    .a(wr_ptr_q), .inc((AW+1)'(1)), .y(wr_nxt)
  );
  addr_mod_add #(.DEPTH(DEPTH), .AW(AW)) u_rd_add (
    .a(rd_base_q), .inc((AW+1)'(STRIDE)), .y(rd_nxt)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    addr_mod_add #(.DEPTH(DEPTH), .AW(AW)) u_slice (
      .a(rd_base_q), .inc((AW+1)'(k)), .y(rd_addr[k*AW +: AW])
    );
  end
  always_comb begin
    run       = state_q == RUN;
    busy      = run;
    full      = occ_q == OW'(DEPTH);
    rd_valid  = run & (occ_q >= OW'(WIN));
    wr_acc    = run & wr_en & ~full;
    rd_acc    = rd_en & rd_valid;
    wr_addr   = wr_ptr_q;
    wr_wrap   = wr_wrap_q;
    state_d   = start ? RUN : stop ? IDLE : state_q;
    wr_ptr_d  = start ? '0 : wr_acc ? wr_nxt : wr_ptr_q;
    rd_base_d = start ? '0 : rd_acc ? rd_nxt : rd_base_q;
    occ_d     = start ? '0 : occ_q + OW'(wr_acc) - (rd_acc ? OW'(STRIDE) : OW'(0));
    wr_wrap_d = ~start & wr_acc & (wr_nxt == '0);
`ifdef ADDR_SEQ_ONEHOT_EN
    onehot_d  = start ? DEPTH'(1) : wr_acc ? DEPTH'(1) << wr_nxt : onehot_q;
    wr_onehot = onehot_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_base_q <= '0;
      occ_q     <= '0;
      wr_wrap_q <= 1'b0;
`ifdef ADDR_SEQ_ONEHOT_EN
      onehot_q  <= DEPTH'(1);
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_base_q <= rd_base_d;
      occ_q     <= occ_d;
      wr_wrap_q <= wr_wrap_d;
`ifdef ADDR_SEQ_ONEHOT_EN
      onehot_q  <= onehot_d;
`endif
    end
  end
endmodule
